// File: rtl/score_pkg.sv
// score_pkg: FSM states, brick colour codes and the colour-to-points lookup.
package score_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ONES, S_TENS, S_HUNDREDS, S_THOUSANDS} state_t;
  localparam int BCD_MAX = 9;
  localparam int PTS_W = 3;
  localparam logic [7:0] COL_6C = 8'h6C;
  localparam logic [7:0] COL_6D = 8'h6D;
  localparam logic [7:0] COL_FC = 8'hFC;
  localparam logic [7:0] COL_E0 = 8'hE0;
  localparam logic [7:0] COL_60 = 8'h60;
  localparam logic [7:0] COL_03 = 8'h03;
  localparam logic [7:0] COL_1C = 8'h1C;
  localparam logic [7:0] COL_1F = 8'h1F;
  localparam logic [7:0] COL_E3 = 8'hE3;
  function automatic logic [PTS_W-1:0] color_points(input logic [7:0] c);
    case (c)
      COL_6C, COL_6D, COL_FC: color_points = 3'd5;
      COL_E0, COL_60:         color_points = 3'd3;
      COL_03, COL_1C, COL_1F: color_points = 3'd4;
      COL_E3:                 color_points = 3'd6;
      default:                color_points = 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/score_fifo.sv
// score_fifo: pending-event queue with synchronous flush and a look-ahead head output.
module score_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wr] <= i_din;
  end
  assign o_dout = r_mem[r_rd];
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/score_scheduler.sv
// score_scheduler: round-robin hit arbiter feeding a digit-serial BCD score adder.
import score_pkg::*;
module score_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 newGame,
  input  logic [NUM_REQ-1:0]   hitReq,
  input  logic [NUM_REQ*8-1:0] hitColor,
  output logic [NUM_REQ-1:0]   hitGnt,
  output logic [3:0]           score1,
  output logic [3:0]           score10,
  output logic [3:0]           score100,
  output logic [3:0]           score1000,
  output logic                 busy,
  output logic                 queueFull,
  output logic                 scoreSaturated
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, w_idx, w_cand;
  logic w_found, w_grant, w_push, w_pop, w_full, w_empty, w_cout;
  logic [CW-1:0] w_count;
  logic [7:0] w_colors [NUM_REQ];
  logic [PTS_W-1:0] w_pts, w_head, r_pts;
  logic [3:0] r_s1, r_s10, r_s100, r_s1000, r_sh1, r_sh10, r_sh100, w_base, w_dig;
  logic [4:0] w_sum;
  logic r_carry, r_sat;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_col
    assign w_colors[g] = hitColor[8*g +: 8];
  end
  // search starts at r_ptr, the requester after the last one granted
  always_comb begin
    w_found = 1'b0;
    w_idx = '0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && hitReq[w_cand]) begin
        w_found = 1'b1;
        w_idx = w_cand;
      end
    end
  end
  assign w_grant = resetN && !newGame && !w_full && w_found;
  assign hitGnt = w_grant ? NUM_REQ'(1) << w_idx : '0;
  assign w_pts = color_points(w_colors[w_idx]);
  assign w_push = w_grant && (w_pts != '0);
  assign w_pop = (r_state == S_IDLE) && !w_empty && !newGame;
  score_fifo #(.WIDTH(PTS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .i_clr   (newGame),
    .i_push  (w_push),
    .i_din   (w_pts),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_ptr <= '0;
    else if (newGame) r_ptr <= '0;
    else if (w_grant) r_ptr <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // one digit per state; the committed digit feeds the adder so outputs only move at commit
  always_comb begin
    w_next = newGame ? S_IDLE :
             r_state == S_IDLE ? (w_empty ? S_IDLE : S_ONES) :
             r_state == S_THOUSANDS ? S_IDLE : state_t'(r_state + 3'd1);
    w_base = r_state == S_ONES ? r_s1 :
             r_state == S_TENS ? r_s10 :
             r_state == S_HUNDREDS ? r_s100 : r_s1000;
    w_sum = {1'b0, w_base} + (r_state == S_ONES ? 5'(r_pts) : 5'(r_carry));
    w_cout = w_sum > 5'(BCD_MAX);
    w_dig = w_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN || newGame) begin
      r_pts <= '0;
      r_carry <= 1'b0;
      r_sh1 <= '0;
      r_sh10 <= '0;
      r_sh100 <= '0;
      r_s1 <= '0;
      r_s10 <= '0;
      r_s100 <= '0;
      r_s1000 <= '0;
      r_sat <= 1'b0;
    end else begin
      if (w_pop) r_pts <= w_head;
      if (r_state != S_IDLE) r_carry <= w_cout;
      if (r_state == S_ONES) r_sh1 <= w_dig;
      if (r_state == S_TENS) r_sh10 <= w_dig;
      if (r_state == S_HUNDREDS) r_sh100 <= w_dig;
      if (r_state == S_THOUSANDS) begin
        r_s1 <= w_cout ? 4'(BCD_MAX) : r_sh1;
        r_s10 <= w_cout ? 4'(BCD_MAX) : r_sh10;
        r_s100 <= w_cout ? 4'(BCD_MAX) : r_sh100;
        r_s1000 <= w_cout ? 4'(BCD_MAX) : w_dig;
        if (w_cout) r_sat <= 1'b1;
      end
    end
  end
  assign score1 = r_s1;
  assign score10 = r_s10;
  assign score100 = r_s100;
  assign score1000 = r_s1000;
  assign scoreSaturated = r_sat;
  assign queueFull = w_full;
  assign busy = (r_state != S_IDLE) || (w_count != '0);
endmodule

// File: tb/tb_score_scheduler.sv
// tb_score_scheduler: directed scenarios checked every cycle against an event-level score model.
module tb_score_scheduler;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic newGame = 1'b0;
  logic [N-1:0] hitReq = '0;
  logic [N*8-1:0] hitColor = '0;
  logic [N-1:0] hitGnt;
  logic [3:0] score1, score10, score100, score1000;
  logic busy, queueFull, scoreSaturated;
  int n_chk = 0;
  int n_fail = 0;
  int m_q[$];
  int m_score = 0, m_sat = 0, m_cnt = 0, m_cur = 0, m_ptr = 0;

  always #5 clk = ~clk;

  score_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .resetN(resetN), .newGame(newGame), .hitReq(hitReq), .hitColor(hitColor),
    .hitGnt(hitGnt), .score1(score1), .score10(score10), .score100(score100),
    .score1000(score1000), .busy(busy), .queueFull(queueFull), .scoreSaturated(scoreSaturated)
  );

  function automatic int pts(input logic [7:0] c);
    case (c)
      8'h6C, 8'h6D, 8'hFC: return 5;
      8'hE0, 8'h60:        return 3;
      8'h03, 8'h1C, 8'h1F: return 4;
      8'hE3:               return 6;
      default:             return 0;
    endcase
  endfunction

  function automatic int exp_gnt_idx();
    if (!resetN || newGame || m_q.size() >= D) return -1;
    for (int k = 0; k < N; k++) if (hitReq[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int score_val();
    return int'(score1000) * 1000 + int'(score100) * 100 + int'(score10) * 10 + int'(score1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_score = 0;
    m_sat = 0;
    m_cnt = 0;
    m_cur = 0;
    m_ptr = 0;
  endtask

  // an event is popped when the adder is free and lands on the score 4 edges later
  task automatic model_edge();
    int j;
    int p;
    j = exp_gnt_idx();
    if (!resetN || newGame) begin
      model_clear();
      return;
    end
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_score += m_cur;
        if (m_score > 9999) begin
          m_score = 9999;
          m_sat = 1;
        end
      end
    end else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_cnt = 4;
    end
    if (j >= 0) begin
      p = pts(hitColor[8*j +: 8]);
      if (p != 0) m_q.push_back(p);
      m_ptr = (j + 1) % N;
    end
  endtask

  task automatic tick();
    int j;
    logic [N-1:0] g;
    @(negedge clk);
    j = exp_gnt_idx();
    chk("hitGnt", int'(hitGnt), j < 0 ? 0 : (1 << j));
    chk("score", score_val(), m_score);
    chk("busy", int'(busy), int'(m_cnt > 0 || m_q.size() > 0));
    chk("queueFull", int'(queueFull), int'(m_q.size() == D));
    chk("scoreSaturated", int'(scoreSaturated), m_sat);
    g = hitGnt;
    @(posedge clk);
    model_edge();
    #1;
    hitReq = hitReq & ~g;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && (m_cnt > 0 || m_q.size() > 0); i++) tick();
    if (i == 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: still busy after 400 cycles at %0t", $time);
    end
    tick();
  endtask

  task automatic hit(input int r, input logic [7:0] c);
    int i;
    hitColor[8*r +: 8] = c;
    hitReq[r] = 1'b1;
    for (i = 0; i < 100 && hitReq[r]; i++) tick();
    if (hitReq[r]) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout: requester %0d never granted at %0t", r, $time);
      hitReq[r] = 1'b0;
    end
  endtask

  task automatic pulse_new();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
  endtask

  initial begin
    int bad;
    model_clear();
    hitReq = 4'b0001;
    #2;
    chk("rst_gnt", int'(hitGnt), 0);
    chk("rst_score", score_val(), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(queueFull), 0);
    chk("rst_sat", int'(scoreSaturated), 0);
    tick();
    tick();
    hitReq = '0;
    resetN = 1'b1;
    tick();

    hitColor[7:0] = 8'hE3;
    hitReq = 4'b0001;
    #1;
    chk("s1_gnt", int'(hitGnt), 1);
    tick();
    chk("s1_busy_mid", int'(busy), 1);
    repeat (4) tick();
    chk("s1_no_early_commit", score_val(), 0);
    tick();
    chk("s1_score", score_val(), 6);
    chk("s1_busy_after", int'(busy), 0);

    hitColor[23:16] = 8'h55;
    hitReq = 4'b0100;
    #1;
    chk("s6_gnt", int'(hitGnt), 4);
    tick();
    chk("s6_busy", int'(busy), 0);
    repeat (6) tick();
    chk("s6_score", score_val(), 6);

    pulse_new();
    repeat (13) hit(0, 8'hE3);
    repeat (4) hit(1, 8'h6C);
    wait_idle();
    chk("s2_base", score_val(), 98);
    hit(2, 8'h6C);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (score_val() != 98 && score_val() != 103) bad = 1;
    end
    chk("s2_no_partial", bad, 0);
    chk("s2_score", score_val(), 103);

    pulse_new();
    hitColor = {N{8'hE0}};
    hitReq = 4'b1111;
    #1;
    chk("s3_gnt0", int'(hitGnt), 1);
    tick();
    #1;
    chk("s3_gnt1", int'(hitGnt), 2);
    tick();
    #1;
    chk("s3_gnt2", int'(hitGnt), 4);
    tick();
    #1;
    chk("s3_gnt3", int'(hitGnt), 8);
    tick();
    wait_idle();
    chk("s3_score", score_val(), 12);
    hitReq = 4'b1000;
    tick();
    hitReq = 4'b1111;
    repeat (4) tick();
    chk("s3_full", int'(queueFull), 1);
    hitReq = 4'b0010;
    #1;
    chk("s3_no_gnt_full", int'(hitGnt), 0);
    tick();
    hitReq = '0;
    wait_idle();
    chk("s3_score2", score_val(), 27);

    pulse_new();
    repeat (1665) hit(0, 8'hE3);
    hit(0, 8'hE0);
    hit(0, 8'h03);
    wait_idle();
    chk("s4_base", score_val(), 9997);
    chk("s4_sat_pre", int'(scoreSaturated), 0);
    hit(0, 8'h6C);
    wait_idle();
    chk("s4_score", score_val(), 9999);
    chk("s4_sat", int'(scoreSaturated), 1);
    hit(0, 8'hE0);
    wait_idle();
    chk("s4_hold", score_val(), 9999);
    chk("s4_sat_hold", int'(scoreSaturated), 1);

    hitColor = {N{8'hE0}};
    hitReq = 4'b1000;
    tick();
    hitColor = {N{8'h6C}};
    hitReq = 4'b1111;
    repeat (4) tick();
    repeat (3) tick();
    chk("s5_busy_pre", int'(busy), 1);
    chk("s5_full_pre", int'(queueFull), 0);
    newGame = 1'b1;
    hitReq = 4'b0010;
    #1;
    chk("s5_gnt_suppressed", int'(hitGnt), 0);
    tick();
    newGame = 1'b0;
    hitReq = '0;
    #1;
    chk("s5_score", score_val(), 0);
    chk("s5_busy", int'(busy), 0);
    chk("s5_full", int'(queueFull), 0);
    chk("s5_sat", int'(scoreSaturated), 0);
    repeat (3) tick();

    hit(0, 8'hE3);
    wait_idle();
    chk("r_base", score_val(), 6);
    hitColor = {N{8'hE3}};
    hitReq = 4'b1111;
    repeat (3) tick();
    #2;
    resetN = 1'b0;
    model_clear();
    #1;
    chk("r_score", score_val(), 0);
    chk("r_busy", int'(busy), 0);
    chk("r_full", int'(queueFull), 0);
    chk("r_gnt", int'(hitGnt), 0);
    tick();
    resetN = 1'b1;
    hitReq = '0;
    repeat (10) tick();
    chk("r_no_commit", score_val(), 0);
    chk("r_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
